// File: rtl/cnt_sched_pkg.sv
// Shared types and default sizing for the count scheduler.
package cnt_sched_pkg;

   localparam int unsigned NREQ_DEF = 4;
   localparam int unsigned CW_DEF   = 8;
   localparam int unsigned LW_DEF   = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_FINISH
   } state_e;

endpackage

// File: rtl/count_scheduler_counter.sv
// Shared up-counter: synchronous clear wins over enable, wraps modulo 2^CW.
module up_counter_w import cnt_sched_pkg::*; #(
   parameter int unsigned CW = CW_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          clear,
   input  logic          enable,
   output logic [CW-1:0] out
);

   logic [CW-1:0] out_q;
   logic [CW-1:0] out_d;

   always_comb begin
      out_d = out_q;
      if (clear) begin
         out_d = '0;
      end else if (enable) begin
         out_d = out_q + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: rtl/count_scheduler.sv
// Round-robin burst scheduler: each grant clears the shared counter, counts
// the winner's latched burst length, then pulses done (aborted on withdrawal).
module count_scheduler import cnt_sched_pkg::*; #(
   parameter int unsigned NREQ = NREQ_DEF,
   parameter int unsigned CW   = CW_DEF,
   parameter int unsigned LW   = LW_DEF
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*LW-1:0] len,
   output logic [NREQ-1:0]    gnt,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [CW-1:0]      count
);

   localparam int unsigned IW = $clog2(NREQ);

   state_e          state_q, state_d;
   logic [IW-1:0]   win_q, win_d;
   logic [IW-1:0]   last_q, last_d;
   logic [LW-1:0]   rem_q, rem_d;
   logic            wd_q, wd_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            aborted_q, aborted_d;

   logic [LW-1:0]   len_a [NREQ];
   logic            pick_found_c;
   logic [IW-1:0]   pick_idx_c;
   logic            req_win_c;
   logic            cnt_clear_c;
   logic            cnt_en_c;

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         len_a[i] = len[i*LW +: LW];
      end
   end

   // Round-robin search begins one past the previous winner.
   always_comb begin
      pick_found_c = 1'b0;
      pick_idx_c   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         if (!pick_found_c && req[IW'((32'(last_q) + k) % NREQ)]) begin
            pick_found_c = 1'b1;
            pick_idx_c   = IW'((32'(last_q) + k) % NREQ);
         end
      end
   end

   assign req_win_c = req[win_q];

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      last_d      = last_q;
      rem_d       = rem_q;
      wd_d        = wd_q;
      gnt_d       = gnt_q;
      done_d      = 1'b0;
      aborted_d   = 1'b0;
      cnt_clear_c = 1'b0;
      cnt_en_c    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_found_c) begin
               win_d   = pick_idx_c;
               rem_d   = len_a[pick_idx_c];
               wd_d    = 1'b0;
               gnt_d   = NREQ'(1) << pick_idx_c;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            cnt_clear_c = 1'b1;
            if (!req_win_c) begin
               wd_d    = 1'b1;
               state_d = ST_FINISH;
            end else if (rem_q == '0) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A withdrawn cycle does not count; the partial value is kept.
            if (!req_win_c) begin
               wd_d    = 1'b1;
               state_d = ST_FINISH;
            end else begin
               cnt_en_c = 1'b1;
               rem_d    = rem_q - LW'(1);
               if (rem_q == LW'(1)) begin
                  state_d = ST_FINISH;
               end
            end
         end
         ST_FINISH: begin
            done_d    = 1'b1;
            aborted_d = wd_q;
            gnt_d     = '0;
            last_d    = win_q;
            state_d   = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy_d = (state_d != ST_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         win_q     <= '0;
         last_q    <= IW'(NREQ - 1);
         rem_q     <= '0;
         wd_q      <= 1'b0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         last_q    <= last_d;
         rem_q     <= rem_d;
         wd_q      <= wd_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   up_counter_w #(.CW(CW)) u_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear_c),
      .enable (cnt_en_c),
      .out    (count)
   );

   assign gnt     = gnt_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign aborted = aborted_q;

endmodule
